byte_data_memory: RTL

Parametrised data memory for the single-cycle MIPS datapath, supporting byte, halfword and word stores and loads with sign or zero extension. Depth is configurable, and reads are registered. A post-reset clear sequencer zeroes the whole array, and misaligned accesses are detected and flagged. It replaces the fixed 256-word, word-only data memory and sits between the ALU address output and the write-back mux.

---
 rtl/byte_data_memory.sv | 82 ++++++++
 1 files changed

// File: rtl/byte_data_memory.sv
// byte_data_memory: big-endian byte/half/word data memory with registered loads,
// post-reset clear sequencer and misalignment flagging.
module byte_data_memory #(
    parameter int DEPTH_WORDS    = 4096,
    parameter bit CLEAR_ON_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic        ready,
    output logic        rd_valid,
    output logic [31:0] read_data,
    output logic        err
);
    localparam int IDX = $clog2(DEPTH_WORDS);
    typedef enum logic {CLEAR, READY} state_t;
    state_t state, state_nx;
    logic [IDX-1:0] cnt, idx, waddr;
    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] word, ld, wdata, rdat;
    logic [15:0] lh;
    logic [7:0] lb;
    logic [3:0] we;
    logic [1:0] ofs;
    logic bad, acc, resp, rv, er;
    logic unused_addr;
    assign unused_addr = ^address[31:IDX+2];
    always_comb begin
        idx      = address[IDX+1:2];
        ofs      = address[1:0];
        ready    = state == READY && !reset;
        acc      = ready && req_valid;
        bad      = req_size == 2'b11 || (req_size == 2'b01 && ofs[0]) || (req_size == 2'b10 && ofs != 2'b00);
        resp     = acc && (!req_write || bad);
        word     = mem[idx];
        // offset 0 is the most significant byte, so shift right by (3 - offset) bytes
        lb       = 8'(word >> {~ofs, 3'b000});
        lh       = ofs[1] ? word[15:0] : word[31:16];
        ld       = req_size == 2'b10 ? word :
                   req_size == 2'b01 ? (req_unsigned ? {16'h0, lh} : {{16{lh[15]}}, lh}) :
                   (req_unsigned ? {24'h0, lb} : {{24{lb[7]}}, lb});
        we       = reset ? 4'h0 :
                   state == CLEAR ? 4'hF :
                   !(acc && req_write && !bad) ? 4'h0 :
                   req_size == 2'b00 ? 4'b1000 >> ofs :
                   req_size == 2'b01 ? (ofs[1] ? 4'b0011 : 4'b1100) : 4'hF;
        waddr    = state == CLEAR ? cnt : idx;
        wdata    = state == CLEAR ? 32'h0 :
                   req_size == 2'b00 ? {4{write_data[7:0]}} :
                   req_size == 2'b01 ? {2{write_data[15:0]}} : write_data;
        state_nx = (state == CLEAR && cnt == IDX'(DEPTH_WORDS - 1)) ? READY : state;
        rd_valid = rv && !reset;
        err      = er && !reset;
        read_data = reset ? 32'h0 : rdat;
    end
    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (we[i]) mem[waddr][8*i +: 8] <= wdata[8*i +: 8];
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= CLEAR_ON_RESET ? CLEAR : READY;
            cnt   <= '0;
            rv    <= 1'b0;
            rdat  <= 32'h0;
            er    <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= state == CLEAR ? cnt + 1'b1 : cnt;
            rv    <= resp;
            if (resp) begin
                rdat <= bad ? 32'h0 : ld;
                er   <= bad;
            end
        end
    end
endmodule
